boot_ctrl: RTL and testbench
============================

BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter LOAD_LEN, default 16, number of program bytes loaded per boot (range 1..256).
REQ-002 Parameter ADDR_W, default 8, memory address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; request a program load from IDLE or HALTED.
REQ-006 abort  input  1  level; cancel an in-progress load.
REQ-007 in_data  input  8  program byte from the host stream.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  the block accepts in_data this cycle.
REQ-010 mem_sel  output  1  1 = loader owns the memory bus, 0 = CPU owns it.
REQ-011 mem_we  output  1  memory write strobe.
REQ-012 mem_addr  output  ADDR_W  write address.
REQ-013 mem_wdata  output  8  write data.
REQ-014 cpu_halt  input  1  halt flag from control_unit.
REQ-015 cpu_reset  output  1  holds the CPU (PC, IR, FSM) in reset while 1.
REQ-016 running  output  1  the CPU is executing.
REQ-017 halted  output  1  the CPU has halted since the last boot.
REQ-018 load_count  output  ADDR_W  number of bytes accepted in the current load.

Function
REQ-019 States SHALL be IDLE, LOAD, BOOT, RUN and HALTED.
REQ-020 IDLE: cpu_reset=1, all other outputs 0; start=1 -> LOAD with load_count cleared to 0.
REQ-021 LOAD outputs: in_ready=1, mem_sel=1, cpu_reset=1.
REQ-022 LOAD handshake: a byte is accepted when in_valid & in_ready & !abort.
REQ-023 On acceptance, in the same cycle: mem_we=1, mem_addr=load_count, mem_wdata=in_data (combinational pass-through); load_count increments on the next edge.
REQ-024 LOAD: acceptance while load_count==LOAD_LEN-1 -> BOOT; load_count then equals LOAD_LEN (truncated to ADDR_W bits when LOAD_LEN=2^ADDR_W).
REQ-025 LOAD: abort=1 -> IDLE; abort overrides a simultaneous handshake (mem_we=0, in_ready=0 that cycle); load_count is cleared.
REQ-026 LOAD: start is ignored; in_valid=0 leaves state and load_count unchanged (stalls of any length are allowed).
REQ-027 BOOT: lasts exactly 1 cycle with mem_sel=0 and cpu_reset=1, then -> RUN unconditionally; cpu_halt and abort are ignored.
REQ-028 RUN: cpu_reset=0, running=1, mem_sel=0; cpu_halt=1 -> HALTED; start and abort are ignored.
REQ-029 HALTED: cpu_reset=0 (CPU state preserved for inspection), halted=1, mem_sel=0; start=1 -> LOAD with load_count cleared and cpu_reset=1 from the next cycle.
REQ-030 mem_we SHALL be 0 in every state other than LOAD.
REQ-031 Latency from the final accepted byte to running=1 SHALL be exactly 2 cycles (LOAD->BOOT->RUN).

Reset
REQ-032 reset=1 SHALL force IDLE, load_count=0, cpu_reset=1 and all other outputs 0 at the next edge, from any state including mid-LOAD.
REQ-033 reset SHALL take priority over start, abort, in_valid and cpu_halt.

Structure
REQ-034 The state encodings (IDLE=3'b000, LOAD=3'b001, BOOT=3'b010, RUN=3'b011, HALTED=3'b100) SHALL live in the shared CPU package alongside the control_unit state constants.
REQ-035 The block SHALL be a single module with one registered state and one load_count register; no sub-module.

Verification
REQ-036 reset, start, 16 bytes 0x00..0x0F back-to-back -> writes to addr 0..15 with matching data; running=1 two cycles after the last byte.
REQ-037 LOAD with in_valid toggling 1,0,0,1... -> only valid cycles write; load_count increments only on accepted bytes.
REQ-038 abort asserted together with byte 5 (in_valid=1) -> no write at addr 5; state=IDLE; load_count=0.
REQ-039 RUN, cpu_halt=1 -> halted=1, cpu_reset=0; start -> cpu_reset=1, reload begins at addr 0.
REQ-040 reset asserted mid-LOAD after 7 bytes -> IDLE, load_count=0, mem_we=0; start asserted during RUN -> no effect.

Source files
------------

// File: rtl/boot_ctrl_pkg.sv
// Shared CPU package: boot loader and control_unit state encodings, plus
// the boot loader's per-state output decode.
package boot_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE   = 3'b000,
        BOOT_LOAD   = 3'b001,
        BOOT_BOOT   = 3'b010,
        BOOT_RUN    = 3'b011,
        BOOT_HALTED = 3'b100
    } boot_state_t;

    typedef enum logic [1:0] {
        CU_FETCH   = 2'b00,
        CU_DECODE  = 2'b01,
        CU_EXECUTE = 2'b10,
        CU_HALT    = 2'b11
    } cu_state_t;

    typedef struct packed {
        logic mem_sel;
        logic cpu_reset;
        logic running;
        logic halted;
    } boot_flags_t;

    function automatic boot_flags_t flags_for(boot_state_t s);
        boot_flags_t f;
        f.mem_sel   = (s == BOOT_LOAD);
        f.cpu_reset = (s == BOOT_IDLE) || (s == BOOT_LOAD) || (s == BOOT_BOOT);
        f.running   = (s == BOOT_RUN);
        f.halted    = (s == BOOT_HALTED);
        return f;
    endfunction

endpackage

// File: rtl/boot_ctrl.sv
// Boot loader: streams LOAD_LEN host bytes into program memory, then releases
// the CPU. Writes pass through combinationally; last byte to running = 2 cycles.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int LOAD_LEN = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              cpu_halt,
    output logic              cpu_reset,
    output logic              running,
    output logic              halted,
    output logic [ADDR_W-1:0] load_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_LEN - 1);

    boot_state_t       state;
    boot_state_t       next_state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] next_count;
    boot_flags_t       flags;
    logic              accept;

    assign accept = (state == BOOT_LOAD) && in_valid && !abort;

    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            BOOT_IDLE: begin
                if (start) begin
                    next_state = BOOT_LOAD;
                    next_count = '0;
                end
            end
            BOOT_LOAD: begin
                if (abort) begin
                    next_state = BOOT_IDLE;
                    next_count = '0;
                end else if (accept) begin
                    // Wraps to 0 when LOAD_LEN == 2**ADDR_W.
                    next_count = count + 1'b1;
                    if (count == LAST_IDX) next_state = BOOT_BOOT;
                end
            end
            BOOT_BOOT: next_state = BOOT_RUN;
            BOOT_RUN: begin
                if (cpu_halt) next_state = BOOT_HALTED;
            end
            BOOT_HALTED: begin
                if (start) begin
                    next_state = BOOT_LOAD;
                    next_count = '0;
                end
            end
            default: begin
                next_state = BOOT_IDLE;
                next_count = '0;
            end
        endcase
    end

    // Flags are registered against the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT_IDLE;
            count <= '0;
            flags <= flags_for(BOOT_IDLE);
        end else begin
            state <= next_state;
            count <= next_count;
            flags <= flags_for(next_state);
        end
    end

    assign in_ready   = (state == BOOT_LOAD) && !abort;
    assign mem_we     = accept;
    assign mem_addr   = accept ? count : '0;
    assign mem_wdata  = accept ? in_data : 8'h00;
    assign mem_sel    = flags.mem_sel;
    assign cpu_reset  = flags.cpu_reset;
    assign running    = flags.running;
    assign halted     = flags.halted;
    assign load_count = count;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl with a per-cycle abstract model and memory capture.
module tb_boot_ctrl;

    localparam int LEN = 16;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, in_valid, cpu_halt;
    logic [7:0]    in_data;
    logic          in_ready, mem_sel, mem_we, cpu_reset, running, halted;
    logic [AW-1:0] mem_addr, load_count;
    logic [7:0]    mem_wdata;

    int errors = 0;
    int checks = 0;

    boot_ctrl #(.LOAD_LEN(LEN), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_halt(cpu_halt), .cpu_reset(cpu_reset),
        .running(running), .halted(halted), .load_count(load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: which phase the boot sequence is in, and bytes taken so far.
    bit m_live = 0, m_load = 0, m_boot = 0, m_run = 0, m_halt = 0;
    int m_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            {m_load, m_boot, m_run, m_halt} = 4'b0;
            m_cnt  = 0;
            m_live = 1;
        end else if (m_live) begin
            if (m_load) begin
                if (abort) begin
                    m_load = 0; m_cnt = 0;
                end else if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == LEN) begin m_load = 0; m_boot = 1; end
                end
            end else if (m_boot) begin
                m_boot = 0; m_run = 1;
            end else if (m_run) begin
                if (cpu_halt) begin m_run = 0; m_halt = 1; end
            end else if (m_halt) begin
                if (start) begin m_halt = 0; m_load = 1; m_cnt = 0; end
            end else if (start) begin
                m_load = 1; m_cnt = 0;
            end
        end
    end

    logic [7:0] mem [256];
    bit         wr  [256];

    always @(negedge clk) begin
        if (m_live) begin
            bit e_we, e_idle;
            e_we   = m_load && in_valid && !abort;
            e_idle = !(m_load || m_boot || m_run || m_halt);
            chk("in_ready",   32'(in_ready),   32'(m_load && !abort));
            chk("mem_we",     32'(mem_we),     32'(e_we));
            chk("mem_sel",    32'(mem_sel),    32'(m_load));
            chk("cpu_reset",  32'(cpu_reset),  32'(!(m_run || m_halt)));
            chk("running",    32'(running),    32'(m_run));
            chk("halted",     32'(halted),     32'(m_halt));
            chk("load_count", 32'(load_count), 32'(m_cnt % 256));
            if (e_we) begin
                chk("mem_addr",  32'(mem_addr),  32'(m_cnt));
                chk("mem_wdata", 32'(mem_wdata), 32'(in_data));
            end
            if (e_idle) begin
                chk("idle_addr",  32'(mem_addr),  32'h0);
                chk("idle_wdata", 32'(mem_wdata), 32'h0);
            end
        end
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr[mem_addr]  = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin wr[i] = 1'b0; mem[i] = 8'h00; end
    endtask

    task automatic load_back_to_back(input logic [7:0] base);
        for (int i = 0; i < LEN; i++) begin
            in_valid = 1; in_data = base + 8'(i);
            step();
        end
        in_valid = 0;
    endtask

    initial begin
        int got, cyc;
        reset = 1; start = 0; abort = 0; in_valid = 0; cpu_halt = 0; in_data = 8'h00;
        clear_mem();
        step(); step();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_running",   32'(running),   32'h0);
        chk("rst_count",     32'(load_count), 32'h0);
        reset = 0;
        step();

        // Back-to-back load of 0x00..0x0F, then 2-cycle release.
        start = 1; step(); start = 0;
        load_back_to_back(8'h00);
        chk("boot_not_running", 32'(running), 32'h0);
        chk("boot_count",       32'(load_count), 32'd16);
        step();
        chk("run_after_2", 32'(running), 32'h1);
        for (int i = 0; i < LEN; i++) begin
            chk("wr_flag", 32'(wr[i]), 32'h1);
            chk("wr_data", 32'(mem[i]), 32'(i));
        end

        // start during RUN has no effect.
        start = 1; step(); start = 0; step();
        chk("run_start_ignored", 32'(running), 32'h1);
        chk("run_cpu_reset",     32'(cpu_reset), 32'h0);

        // Halt, then reload with a 1,0,0 valid pattern.
        cpu_halt = 1; step(); cpu_halt = 0;
        chk("halted",        32'(halted),    32'h1);
        chk("halt_cpu_reset", 32'(cpu_reset), 32'h0);
        clear_mem();
        start = 1; step(); start = 0;
        chk("reload_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("reload_count",     32'(load_count), 32'h0);
        got = 0; cyc = 0;
        while (got < LEN && cyc < 200) begin
            in_valid = (cyc % 3 == 0);
            in_data  = in_valid ? 8'hA0 + 8'(got) : 8'hEE;
            if (in_valid) got++;
            step();
            cyc++;
        end
        in_valid = 0;
        chk("toggle_budget", 32'(cyc < 200), 32'h1);
        chk("toggle_addr0",  32'(mem[0]),  32'hA0);
        chk("toggle_addr15", 32'(mem[15]), 32'hAF);
        chk("toggle_nowr16", 32'(wr[16]),  32'h0);
        step(); step();
        chk("toggle_running", 32'(running), 32'h1);

        // Abort together with byte 5.
        cpu_halt = 1; step(); cpu_halt = 0;
        clear_mem();
        start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 8'h50 + 8'(i); step();
        end
        in_valid = 1; in_data = 8'h55; abort = 1;
        #2;
        chk("abort_we",    32'(mem_we),   32'h0);
        chk("abort_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 0; abort = 0;
        chk("abort_nowr5", 32'(wr[5]),  32'h0);
        chk("abort_wr4",   32'(mem[4]), 32'h54);
        chk("abort_count", 32'(load_count), 32'h0);
        chk("abort_idle",  32'({mem_sel, cpu_reset, running, halted}), 32'b0100);
        step();

        // Reset mid-load after 7 bytes, with a byte still offered.
        start = 1; step(); start = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; in_data = 8'(i); step();
        end
        chk("mid_count7", 32'(load_count), 32'd7);
        reset = 1; start = 1; cpu_halt = 1; step();
        chk("rst_mid_count", 32'(load_count), 32'h0);
        chk("rst_mid_we",    32'(mem_we),     32'h0);
        chk("rst_mid_sel",   32'(mem_sel),    32'h0);
        reset = 0; start = 0; cpu_halt = 0; in_valid = 0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, got no finish expected finish");
        $fatal(1);
    end

endmodule
